rst_sync_multi_clk_gating: RTL and testbench
============================================

Name: rst_sync_multi_clk_gating

Overview:
Multi-channel successor to the single-channel reset-synchronised clock gate. One synchronised reset is shared by CH_NUM independent gated clock outputs. Each channel has its own synchronised activity input, a programmable idle-timeout hysteresis counter, and a gate_req/gate_ack handshake, so a clock is only stopped once its downstream logic confirms it is quiesced. The block sits at the root of a clock sub-tree and feeds per-channel gated clocks to peripheral groups.

Parameters:
CH_NUM, 4, number of independent gated clock channels
STAGE_NUM, 2, synchroniser depth for reset de-assertion and for the active inputs (>=2)
IDLE_CNT_W, 8, width of the idle-timeout counter and the idle_thresh input

Ports:
raw_clk  input  1  free-running source clock; the single clock of the block
rst  input  1  asynchronous, active-high reset
active  input  CH_NUM  per-channel activity request, asynchronous to raw_clk
bypass  input  CH_NUM  per-channel quasi-static bypass; 1 = clock always running
idle_thresh  input  IDLE_CNT_W  idle cycles tolerated before a gate request; shared by all channels
gate_ack  input  CH_NUM  per-channel downstream quiesce acknowledge, synchronous to raw_clk
gate_req  output  CH_NUM  per-channel request to stop the clock (registered)
clk_en  output  CH_NUM  per-channel registered enable driven into the gate cell
gen_clk  output  CH_NUM  per-channel gated clock
sync_rst  output  1  synchronised reset, active-high

Behaviour:
- Reset synchroniser: sync_rst asserts asynchronously with rst. It de-asserts on the STAGE_NUM-th raw_clk rising edge after rst falls. All channel state machines are held in RUN while sync_rst=1.
- Active synchroniser: STAGE_NUM-flop chain per bit, reset to 1 by sync_rst, giving sync_active[i].
- Reset values: gate_req=0, clk_en=all 1, state=RUN, idle counter=0. gen_clk follows raw_clk during and after reset.
- Per-channel FSM; all registers clocked by raw_clk.
  - RUN: clk_en=1, gate_req=0. If sync_active=0, go to IDLE, clear the counter, and latch idle_thresh into thr_q.
  - IDLE: clk_en=1, gate_req=0. The counter increments each cycle.
    - If sync_active=1, go to RUN.
    - Else if counter==thr_q, go to REQ.
    - IDLE therefore lasts thr_q+1 cycles; thr_q=0 gives 1 cycle.
    - Changing idle_thresh mid-count has no effect on the count in progress.
  - REQ: gate_req=1, clk_en=1.
    - If sync_active=1, go to RUN (abort; gate_req drops next edge).
    - Else if gate_ack=1, go to GATED.
    - If sync_active=1 and gate_ack=1 arrive in the same cycle, active wins and the next state is RUN.
  - GATED: gate_req=1, clk_en=0. If sync_active=1, go to WAKE.
  - WAKE: clk_en=1, gate_req=0. Stay until gate_ack=0, then go to RUN. This prevents a stale ack from re-gating.
- gate_req and clk_en are registered decodes of the next state, so they change on the same edge as the state.
- Gate cell: each channel instantiates BB_clk_gating with raw_clk, clk_en[i] as active, and bypass[i] as bypass. gen_clk is glitch-free and held low while gated. An enable change takes effect from the next raw_clk high phase.
- Bypass: bypass[i]=1 forces state RUN, clk_en[i]=1, gate_req[i]=0, and gen_clk[i]=raw_clk on the next edge. An in-flight REQ or GATED is abandoned without waiting for gate_ack.
- Latency: raw active falls, then sync_active falls STAGE_NUM edges later. gate_req rises thr_q+2 edges after sync_active falls. From GATED, clk_en returns to 1 one edge after sync_active rises.
- Channels are fully independent; a simultaneous event on several channels is handled per channel in the same cycle.
- rst assertion mid-operation: all channels return immediately (asynchronously) to RUN with clk_en=1 and gate_req=0.
- The counter does not wrap: it stops at thr_q because the state leaves IDLE at that point.

Test Plan:
- Reset release: rst 1→0 → sync_rst falls on the 2nd raw_clk edge; gen_clk toggles throughout; gate_req=0, clk_en=4'hF.
- Timeout gate: idle_thresh=3, drop active[0], hold gate_ack[0]=1 → gate_req[0] rises 5 edges after sync_active[0] falls; clk_en[0]=0 one edge later; gen_clk[0] low; other channels keep toggling.
- Abort: idle_thresh=10, drop active[1], re-raise it after 4 synced cycles → no gate_req[1]. Repeat in REQ with active and gate_ack rising in the same cycle → state RUN, clk_en[1] stays 1.
- Wake with stale ack: channel 2 GATED, raise active with gate_ack[2] still 1 → clk_en[2]=1 after 1 edge; state stays WAKE until gate_ack drops, then RUN; no re-gating occurs.
- Bypass override: channel 3 GATED, assert bypass[3] → gen_clk[3]=raw_clk, clk_en[3]=1 and gate_req[3]=0 on the next edge.
- Async reset mid-GATED: pulse rst while channels 0 and 2 are gated → clk_en=4'hF immediately; sync_rst held high for 2 edges after release.

Source files
------------

// File: rtl/rst_sync_multi_clk_gating.sv
// rst_sync_multi_clk_gating
//   One synchronised reset shared by CH_NUM independently gated clocks. Each
//   channel watches its synchronised activity input, waits a programmable
//   idle time, then asks downstream (gate_req) for permission to stop its
//   clock and only gates once gate_ack confirms the logic is quiesced.
//
// Ports
//   raw_clk      free-running source clock, the only clock of the block
//   rst          asynchronous active-high reset
//   active       per-channel activity request (asynchronous to raw_clk)
//   bypass       per-channel quasi-static bypass, 1 = clock always running
//   idle_thresh  idle cycles tolerated before a gate request (all channels)
//   gate_ack     per-channel quiesce acknowledge (synchronous to raw_clk)
//   gate_req     per-channel registered request to stop the clock
//   clk_en       per-channel registered enable into the gate cell
//   gen_clk      per-channel gated clock
//   sync_rst     synchronised reset, active-high
//
// Channel FSM
//   state | meaning
//   RUN   | clock running, activity present
//   IDLE  | activity gone, counting idle cycles up to thr_q
//   REQ   | gate_req raised, waiting for gate_ack
//   GATED | clock stopped, waiting for activity
//   WAKE  | clock restarted, waiting for a stale gate_ack to drop

// Glitch-free gate: the enable is captured while raw_clk is low, so it can
// only change the output at the start of the next high phase.
module BB_clk_gating (
   input  logic raw_clk,
   input  logic rst,
   input  logic active,
   input  logic bypass,
   output logic gen_clk
);
   logic en_q;

   always_ff @(negedge raw_clk or posedge rst) begin
      if (rst) en_q <= 1'b1;
      else     en_q <= active;
   end

   assign gen_clk = raw_clk & (en_q | bypass);
endmodule

module rst_sync_multi_clk_gating #(
   parameter int CH_NUM     = 4,
   parameter int STAGE_NUM  = 2,
   parameter int IDLE_CNT_W = 8
) (
   input  logic                  raw_clk,
   input  logic                  rst,
   input  logic [CH_NUM-1:0]     active,
   input  logic [CH_NUM-1:0]     bypass,
   input  logic [IDLE_CNT_W-1:0] idle_thresh,
   input  logic [CH_NUM-1:0]     gate_ack,
   output logic [CH_NUM-1:0]     gate_req,
   output logic [CH_NUM-1:0]     clk_en,
   output logic [CH_NUM-1:0]     gen_clk,
   output logic                  sync_rst
);
   typedef enum logic [2:0] {RUN, IDLE, REQ, GATED, WAKE} state_t;

   logic [STAGE_NUM-1:0]  rst_chain;
   logic [CH_NUM-1:0]     act_chain [STAGE_NUM];
   logic [CH_NUM-1:0]     sync_active;
   state_t                state     [CH_NUM];
   logic [IDLE_CNT_W-1:0] cnt       [CH_NUM];
   logic [IDLE_CNT_W-1:0] thr_q     [CH_NUM];

   // Reset synchroniser: asserts with rst, releases after STAGE_NUM edges.
   always_ff @(posedge raw_clk or posedge rst) begin
      if (rst) rst_chain <= '1;
      else     rst_chain <= {rst_chain[STAGE_NUM-2:0], 1'b0};
   end

   assign sync_rst = rst_chain[STAGE_NUM-1];

   // Activity synchroniser, held at "active" while the block is in reset.
   always_ff @(posedge raw_clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGE_NUM; k++) act_chain[k] <= '1;
      end else if (sync_rst) begin
         for (int k = 0; k < STAGE_NUM; k++) act_chain[k] <= '1;
      end else begin
         act_chain[0] <= active;
         for (int k = 1; k < STAGE_NUM; k++) act_chain[k] <= act_chain[k-1];
      end
   end

   assign sync_active = act_chain[STAGE_NUM-1];

   // Outputs are written alongside the state so they change on the same edge.
   always_ff @(posedge raw_clk or posedge rst) begin
      if (rst) begin
         gate_req <= '0;
         clk_en   <= '1;
         for (int i = 0; i < CH_NUM; i++) begin
            state[i] <= RUN;
            cnt[i]   <= '0;
            thr_q[i] <= '0;
         end
      end else if (sync_rst) begin
         gate_req <= '0;
         clk_en   <= '1;
         for (int i = 0; i < CH_NUM; i++) begin
            state[i] <= RUN;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (bypass[i]) begin
               // Abandon any handshake in flight; no ack is awaited.
               state[i]    <= RUN;
               clk_en[i]   <= 1'b1;
               gate_req[i] <= 1'b0;
            end else begin
               case (state[i])
                  RUN: begin
                     if (!sync_active[i]) begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                        thr_q[i] <= idle_thresh;
                     end
                  end
                  IDLE: begin
                     if (sync_active[i]) begin
                        state[i] <= RUN;
                     end else if (cnt[i] == thr_q[i]) begin
                        state[i]    <= REQ;
                        gate_req[i] <= 1'b1;
                     end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                     end
                  end
                  REQ: begin
                     // Activity takes priority over a coincident ack.
                     if (sync_active[i]) begin
                        state[i]    <= RUN;
                        gate_req[i] <= 1'b0;
                     end else if (gate_ack[i]) begin
                        state[i]  <= GATED;
                        clk_en[i] <= 1'b0;
                     end
                  end
                  GATED: begin
                     if (sync_active[i]) begin
                        state[i]    <= WAKE;
                        clk_en[i]   <= 1'b1;
                        gate_req[i] <= 1'b0;
                     end
                  end
                  WAKE: begin
                     // A lingering ack must clear before gating is possible again.
                     if (!gate_ack[i]) state[i] <= RUN;
                  end
                  default: begin
                     state[i]    <= RUN;
                     clk_en[i]   <= 1'b1;
                     gate_req[i] <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_gate
      BB_clk_gating u_gate (
         .raw_clk (raw_clk),
         .rst     (rst),
         .active  (clk_en[i]),
         .bypass  (bypass[i]),
         .gen_clk (gen_clk[i])
      );
   end
endmodule

// File: tb/tb_rst_sync_multi_clk_gating.sv
// Directed bench for rst_sync_multi_clk_gating (CH_NUM=4, STAGE_NUM=2, IDLE_CNT_W=8).
// Inputs change and outputs are sampled 1 ns after a rising edge.
module tb_rst_sync_multi_clk_gating;
   logic       raw_clk = 1'b0;
   logic       rst;
   logic [3:0] active;
   logic [3:0] bypass;
   logic [7:0] idle_thresh;
   logic [3:0] gate_ack;
   logic [3:0] gate_req;
   logic [3:0] clk_en;
   logic [3:0] gen_clk;
   logic       sync_rst;

   int vectors = 0;
   int miscompares = 0;

   always #5 raw_clk = ~raw_clk;

   rst_sync_multi_clk_gating #(.CH_NUM(4), .STAGE_NUM(2), .IDLE_CNT_W(8)) dut (
      .raw_clk     (raw_clk),
      .rst         (rst),
      .active      (active),
      .bypass      (bypass),
      .idle_thresh (idle_thresh),
      .gate_ack    (gate_ack),
      .gate_req    (gate_req),
      .clk_en      (clk_en),
      .gen_clk     (gen_clk),
      .sync_rst    (sync_rst)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge raw_clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; active = 4'hF; bypass = 4'h0; gate_ack = 4'h0; idle_thresh = 8'd0;
      tick(3);
      vectors++; if (sync_rst !== 1'b1) begin miscompares++; $display("FAIL rst_held sync_rst got %b want 1", sync_rst); end
      vectors++; if (clk_en !== 4'hF) begin miscompares++; $display("FAIL rst_clk_en got %h want f", clk_en); end
      vectors++; if (gate_req !== 4'h0) begin miscompares++; $display("FAIL rst_gate_req got %h want 0", gate_req); end
      vectors++; if (gen_clk !== 4'hF) begin miscompares++; $display("FAIL rst_gen_clk_hi got %h want f", gen_clk); end
      #5;
      vectors++; if (gen_clk !== 4'h0) begin miscompares++; $display("FAIL rst_gen_clk_lo got %h want 0", gen_clk); end
      rst = 1'b0;
      tick(1);
      vectors++; if (sync_rst !== 1'b1) begin miscompares++; $display("FAIL rel_edge1 sync_rst got %b want 1", sync_rst); end
      tick(1);
      vectors++; if (sync_rst !== 1'b0) begin miscompares++; $display("FAIL rel_edge2 sync_rst got %b want 0", sync_rst); end
      vectors++; if (gen_clk !== 4'hF) begin miscompares++; $display("FAIL rel_gen_clk got %h want f", gen_clk); end
      tick(3);
   endtask

   // thr=3: sync falls edge 2, IDLE edge 3, REQ edge 3+4=7, GATED edge 8.
   task automatic test_timeout;
      idle_thresh = 8'd3; gate_ack[0] = 1'b1; active[0] = 1'b0;
      tick(4);
      idle_thresh = 8'd50;
      tick(2);
      vectors++; if (gate_req !== 4'h0) begin miscompares++; $display("FAIL timeout_pre gate_req got %h want 0", gate_req); end
      tick(1);
      vectors++; if (gate_req !== 4'h1) begin miscompares++; $display("FAIL timeout_req gate_req got %h want 1", gate_req); end
      vectors++; if (clk_en !== 4'hF) begin miscompares++; $display("FAIL timeout_req clk_en got %h want f", clk_en); end
      tick(1);
      vectors++; if (clk_en !== 4'hE) begin miscompares++; $display("FAIL timeout_gated clk_en got %h want e", clk_en); end
      vectors++; if (gen_clk !== 4'hF) begin miscompares++; $display("FAIL timeout_gen_same_phase got %h want f", gen_clk); end
      tick(1);
      vectors++; if (gen_clk !== 4'hE) begin miscompares++; $display("FAIL timeout_gen_gated got %h want e", gen_clk); end
      vectors++; if (gate_req !== 4'h1) begin miscompares++; $display("FAIL timeout_hold gate_req got %h want 1", gate_req); end
   endtask

   task automatic test_abort;
      idle_thresh = 8'd10; active[1] = 1'b0;
      tick(5);
      active[1] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         vectors++;
         if (gate_req[1] !== 1'b0 || clk_en[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_idle cycle %0d req/en got %b%b want 01", k, gate_req[1], clk_en[1]);
         end
      end
      // thr=0: REQ at edge 4; active sync rises edge 6; ack+active together at edge 7.
      idle_thresh = 8'd0; active[1] = 1'b0;
      tick(4);
      vectors++; if (gate_req[1] !== 1'b1) begin miscompares++; $display("FAIL abort_req_up got %b want 1", gate_req[1]); end
      active[1] = 1'b1;
      tick(2);
      vectors++; if (gate_req[1] !== 1'b1) begin miscompares++; $display("FAIL abort_req_wait got %b want 1", gate_req[1]); end
      gate_ack[1] = 1'b1;
      tick(1);
      vectors++; if (gate_req[1] !== 1'b0) begin miscompares++; $display("FAIL abort_tie gate_req got %b want 0", gate_req[1]); end
      vectors++; if (clk_en[1] !== 1'b1) begin miscompares++; $display("FAIL abort_tie clk_en got %b want 1", clk_en[1]); end
      tick(3);
      vectors++; if (clk_en[1] !== 1'b1 || gate_req[1] !== 1'b0) begin miscompares++; $display("FAIL abort_run_hold req/en got %b%b want 01", gate_req[1], clk_en[1]); end
      gate_ack[1] = 1'b0;
      tick(2);
   endtask

   task automatic test_wake;
      idle_thresh = 8'd0; gate_ack[2] = 1'b1; active[2] = 1'b0;
      tick(4);
      vectors++; if (gate_req[2] !== 1'b1) begin miscompares++; $display("FAIL wake_req got %b want 1", gate_req[2]); end
      tick(1);
      vectors++; if (clk_en[2] !== 1'b0) begin miscompares++; $display("FAIL wake_gated clk_en got %b want 0", clk_en[2]); end
      active[2] = 1'b1;
      tick(2);
      vectors++; if (clk_en[2] !== 1'b0) begin miscompares++; $display("FAIL wake_sync_wait clk_en got %b want 0", clk_en[2]); end
      tick(1);
      vectors++; if (clk_en[2] !== 1'b1) begin miscompares++; $display("FAIL wake_en clk_en got %b want 1", clk_en[2]); end
      vectors++; if (gate_req[2] !== 1'b0) begin miscompares++; $display("FAIL wake_en gate_req got %b want 0", gate_req[2]); end
      // Activity drops again while the stale ack is still high: must stay in WAKE.
      active[2] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         vectors++;
         if (gate_req[2] !== 1'b0 || clk_en[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL wake_hold cycle %0d req/en got %b%b want 01", k, gate_req[2], clk_en[2]);
         end
      end
      gate_ack[2] = 1'b0;
      tick(2);
      vectors++; if (gate_req[2] !== 1'b0) begin miscompares++; $display("FAIL wake_to_idle gate_req got %b want 0", gate_req[2]); end
      tick(1);
      vectors++; if (gate_req[2] !== 1'b1) begin miscompares++; $display("FAIL wake_rearm gate_req got %b want 1", gate_req[2]); end
      active[2] = 1'b1;
      tick(3);
      vectors++; if (gate_req[2] !== 1'b0 || clk_en[2] !== 1'b1) begin miscompares++; $display("FAIL wake_restore req/en got %b%b want 01", gate_req[2], clk_en[2]); end
   endtask

   task automatic test_bypass;
      idle_thresh = 8'd0; gate_ack[3] = 1'b1; active[3] = 1'b0;
      tick(5);
      vectors++; if (clk_en[3] !== 1'b0 || gate_req[3] !== 1'b1) begin miscompares++; $display("FAIL byp_gated req/en got %b%b want 10", gate_req[3], clk_en[3]); end
      tick(1);
      vectors++; if (gen_clk[3] !== 1'b0) begin miscompares++; $display("FAIL byp_gen_low got %b want 0", gen_clk[3]); end
      bypass[3] = 1'b1;
      tick(1);
      vectors++; if (clk_en[3] !== 1'b1) begin miscompares++; $display("FAIL byp_clk_en got %b want 1", clk_en[3]); end
      vectors++; if (gate_req[3] !== 1'b0) begin miscompares++; $display("FAIL byp_gate_req got %b want 0", gate_req[3]); end
      vectors++; if (gen_clk[3] !== 1'b1) begin miscompares++; $display("FAIL byp_gen_hi got %b want 1", gen_clk[3]); end
      #5;
      vectors++; if (gen_clk[3] !== 1'b0) begin miscompares++; $display("FAIL byp_gen_lo got %b want 0", gen_clk[3]); end
      active[3] = 1'b1; gate_ack[3] = 1'b0;
      tick(3);
      bypass[3] = 1'b0;
      tick(2);
      vectors++; if (clk_en[3] !== 1'b1 || gate_req[3] !== 1'b0) begin miscompares++; $display("FAIL byp_release req/en got %b%b want 01", gate_req[3], clk_en[3]); end
   endtask

   task automatic test_async_reset;
      // Channel 0 is still gated from test_timeout; gate channel 2 too.
      idle_thresh = 8'd0; gate_ack[2] = 1'b1; active[2] = 1'b0;
      tick(6);
      vectors++; if (clk_en !== 4'hA) begin miscompares++; $display("FAIL arst_pre clk_en got %h want a", clk_en); end
      rst = 1'b1;
      #1;
      vectors++; if (clk_en !== 4'hF) begin miscompares++; $display("FAIL arst_clk_en got %h want f", clk_en); end
      vectors++; if (gate_req !== 4'h0) begin miscompares++; $display("FAIL arst_gate_req got %h want 0", gate_req); end
      vectors++; if (sync_rst !== 1'b1) begin miscompares++; $display("FAIL arst_sync_rst got %b want 1", sync_rst); end
      vectors++; if (gen_clk !== 4'hF) begin miscompares++; $display("FAIL arst_gen_clk got %h want f", gen_clk); end
      active = 4'hF; gate_ack = 4'h0;
      #2;
      rst = 1'b0;
      tick(1);
      vectors++; if (sync_rst !== 1'b1) begin miscompares++; $display("FAIL arst_rel1 sync_rst got %b want 1", sync_rst); end
      tick(1);
      vectors++; if (sync_rst !== 1'b0) begin miscompares++; $display("FAIL arst_rel2 sync_rst got %b want 0", sync_rst); end
      tick(4);
      vectors++; if (clk_en !== 4'hF || gate_req !== 4'h0) begin miscompares++; $display("FAIL arst_after req %h en %h want 0 f", gate_req, clk_en); end
   endtask

   initial begin
      test_reset;
      test_timeout;
      test_abort;
      test_wake;
      test_bypass;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached after %0d vectors", vectors);
      $fatal(1, "watchdog");
   end
endmodule
